// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the platform reset/clock-enable sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      SYNC     = 3'd0,
      CLK_ON   = 3'd1,
      WAIT_ACK = 3'd2,
      DONE     = 3'd3,
      ERR      = 3'd4
   } seq_state_e;

   localparam int DEF_NUM_UNITS   = 4;
   localparam int DEF_GAP_CYCLES  = 8;
   localparam int DEF_ACK_TIMEOUT = 64;
   localparam int DEF_SYNC_STAGES = 2;

   // One shared counter serves both the gap and the ack timeout.
   function automatic int cnt_width(input int gap, input int tmo);
      int max_v;
      max_v = (gap > tmo) ? gap : tmo;
      return (max_v > 1) ? $clog2(max_v) : 1;
   endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Unit-facing handshake bundle of the reset sequencer.
interface rst_seq_ctrl_if #(
   parameter int NUM_UNITS = 4,
   parameter int IDX_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
);
   logic [NUM_UNITS-1:0] unit_ack_i;
   logic                 sw_rst_req_i;
   logic [NUM_UNITS-1:0] unit_rst_n_o;
   logic [NUM_UNITS-1:0] clk_en_o;
   logic                 seq_done_o;
   logic                 seq_err_o;
   logic [IDX_W-1:0]     err_unit_o;

   modport master (
      input  unit_ack_i, sw_rst_req_i,
      output unit_rst_n_o, clk_en_o, seq_done_o, seq_err_o, err_unit_o
   );

   modport slave (
      output unit_ack_i, sw_rst_req_i,
      input  unit_rst_n_o, clk_en_o, seq_done_o, seq_err_o, err_unit_o
   );
endinterface

// File: rtl/rst_seq_ctrl_rst_sync.sv
// Async-assert / sync-deassert reset synchronizer, reusable across platform blocks.
module rst_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   output logic rst_n,
   output logic rst_n_nxt
);
   logic [STAGES-1:0] sync_r;

   // Shift ones in after release; any assertion clears the chain at once.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync_r <= {STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], 1'b1};
      end
   end

   assign rst_n     = sync_r[STAGES-1];
   // Value the final stage takes at the next edge, so consumers can act on the release edge itself.
   assign rst_n_nxt = sync_r[STAGES-2];
endmodule

// File: rtl/rst_seq_ctrl.sv
// Releases downstream units one at a time: clock on with reset held, reset off,
// then wait for the unit's ack with a timeout.
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int NUM_UNITS   = DEF_NUM_UNITS,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic           clk_fr,
   input  logic           rst,
   rst_seq_ctrl_if.master bus
);
   localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int CNT_W = cnt_width(GAP_CYCLES, ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_UNITS - 1);

   seq_state_e           state_r, state_s;
   logic [IDX_W-1:0]     idx_r, idx_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic [NUM_UNITS-1:0] clk_en_r, clk_en_s;
   logic [NUM_UNITS-1:0] unit_rst_n_r, unit_rst_n_s;
   logic                 done_r, done_s;
   logic                 err_r, err_s;
   logic [IDX_W-1:0]     err_unit_r, err_unit_s;

   logic rst_int_n_s, rst_int_nxt_s, sync_rel_s;
   logic unit_clk_on_s, gap_end_s, tmo_end_s, ack_s, last_s, sw_s;

   rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
      .clk       (clk_fr),
      .arst_n    (rst),
      .rst_n     (rst_int_n_s),
      .rst_n_nxt (rst_int_nxt_s)
   );

   assign sync_rel_s    = rst_int_nxt_s & ~rst_int_n_s;
   assign unit_clk_on_s = clk_en_r[idx_r];
   assign gap_end_s     = (cnt_r == GAP_LAST);
   assign tmo_end_s     = (cnt_r == TMO_LAST);
   assign ack_s         = bus.unit_ack_i[idx_r];
   assign last_s        = (idx_r == IDX_LAST);
   assign sw_s          = bus.sw_rst_req_i;

   // State, unit index and shared gap/timeout counter.
   always_ff @(posedge clk_fr or negedge rst) begin
      if (!rst) begin
         state_r <= SYNC;
         idx_r   <= {IDX_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state decode; the counter restarts from zero on every state entry.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      case (state_r)
         SYNC: begin
            if (sync_rel_s) begin
               state_s = CLK_ON;
               idx_s   = {IDX_W{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = SYNC;
            end
         end
         CLK_ON: begin
            // After a software restart the clock is enabled one cycle into the state; the gap starts then.
            if (!unit_clk_on_s) begin
               cnt_s = {CNT_W{1'b0}};
            end else if (gap_end_s) begin
               state_s = WAIT_ACK;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         WAIT_ACK: begin
            if (ack_s) begin
               cnt_s = {CNT_W{1'b0}};
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  state_s = CLK_ON;
                  idx_s   = idx_r + IDX_W'(1);
               end
            end else if (tmo_end_s) begin
               state_s = ERR;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         DONE, ERR: begin
            if (sw_s) begin
               state_s = CLK_ON;
               idx_s   = {IDX_W{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         default: begin
            state_s = SYNC;
            idx_s   = {IDX_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Next output values; released units stay released until a restart.
   always_comb begin
      clk_en_s     = clk_en_r;
      unit_rst_n_s = unit_rst_n_r;
      done_s       = done_r;
      err_s        = err_r;
      err_unit_s   = err_unit_r;
      case (state_r)
         SYNC: begin
            if (sync_rel_s) begin
               clk_en_s[0] = 1'b1;
            end else begin
               clk_en_s = {NUM_UNITS{1'b0}};
            end
         end
         CLK_ON: begin
            if (!unit_clk_on_s) begin
               clk_en_s[idx_r] = 1'b1;
            end else if (gap_end_s) begin
               unit_rst_n_s[idx_r] = 1'b1;
            end else begin
               unit_rst_n_s = unit_rst_n_r;
            end
         end
         WAIT_ACK: begin
            if (ack_s) begin
               if (last_s) begin
                  done_s = 1'b1;
               end else begin
                  clk_en_s[idx_s] = 1'b1;
               end
            end else if (tmo_end_s) begin
               err_s      = 1'b1;
               err_unit_s = idx_r;
            end else begin
               err_s = err_r;
            end
         end
         DONE, ERR: begin
            if (sw_s) begin
               clk_en_s     = {NUM_UNITS{1'b0}};
               unit_rst_n_s = {NUM_UNITS{1'b0}};
               done_s       = 1'b0;
               err_s        = 1'b0;
               err_unit_s   = {IDX_W{1'b0}};
            end else begin
               done_s = done_r;
            end
         end
         default: begin
            clk_en_s     = {NUM_UNITS{1'b0}};
            unit_rst_n_s = {NUM_UNITS{1'b0}};
            done_s       = 1'b0;
            err_s        = 1'b0;
            err_unit_s   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Output registers, cleared asynchronously by the global reset.
   always_ff @(posedge clk_fr or negedge rst) begin
      if (!rst) begin
         clk_en_r     <= {NUM_UNITS{1'b0}};
         unit_rst_n_r <= {NUM_UNITS{1'b0}};
         done_r       <= 1'b0;
         err_r        <= 1'b0;
         err_unit_r   <= {IDX_W{1'b0}};
      end else begin
         clk_en_r     <= clk_en_s;
         unit_rst_n_r <= unit_rst_n_s;
         done_r       <= done_s;
         err_r        <= err_s;
         err_unit_r   <= err_unit_s;
      end
   end

   assign bus.clk_en_o     = clk_en_r;
   assign bus.unit_rst_n_o = unit_rst_n_r;
   assign bus.seq_done_o   = done_r;
   assign bus.seq_err_o    = err_r;
   assign bus.err_unit_o   = err_unit_r;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: per-cycle comparison of all outputs against a release schedule
// computed from the sequencing rules (release times, ack window, timeout).
module tb_rst_seq_ctrl;
   import rst_seq_pkg::*;

   localparam int NU   = DEF_NUM_UNITS;
   localparam int GAP  = DEF_GAP_CYCLES;
   localparam int TMO  = DEF_ACK_TIMEOUT;
   localparam int SS   = DEF_SYNC_STAGES;
   localparam int IW   = (NU > 1) ? $clog2(NU) : 1;
   localparam int OW   = 2 * NU + 2 + IW;
   localparam int MAXC = 512;
   localparam int NONE = -1000;
   localparam int M_NOM = 0, M_TMO2 = 1, M_BND = 2, M_STUCK = 3, M_RAND = 4;

   logic clk_fr = 1'b0;
   logic rst    = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [NU-1:0] wave [MAXC];
   int t_clk [NU];
   int t_rel [NU];
   int t_done, t_err, err_idx, end_n;

   rst_seq_ctrl_if #(.NUM_UNITS(NU), .IDX_W(IW)) bus ();

   rst_seq_ctrl #(
      .NUM_UNITS(NU), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO), .SYNC_STAGES(SS)
   ) dut (
      .clk_fr (clk_fr),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_fr = ~clk_fr;

   function automatic logic [OW-1:0] observed();
      return {bus.unit_rst_n_o, bus.clk_en_o, bus.seq_done_o, bus.seq_err_o, bus.err_unit_o};
   endfunction

   // Expected outputs after edge n of the current run, from the planned event times.
   function automatic logic [OW-1:0] expect_at(input int n);
      logic [NU-1:0] ce, ur;
      logic dn, er;
      logic [IW-1:0] eu;
      ce = '0;
      ur = '0;
      for (int i = 0; i < NU; i++) begin
         if (t_clk[i] >= 0 && n >= t_clk[i]) ce[i] = 1'b1;
         if (t_rel[i] >= 0 && n >= t_rel[i]) ur[i] = 1'b1;
      end
      dn = (t_done >= 0) && (n >= t_done);
      er = (t_err >= 0) && (n >= t_err);
      eu = er ? IW'(err_idx) : '0;
      return {ur, ce, dn, er, eu};
   endfunction

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b (unit_rst_n,clk_en,done,err,err_unit)", tag, obs, exp);
      end
   endtask

   // Build the ack waveform and derive release/ack/done/error edges, E0 at edge e0.
   task automatic plan(input int mode, input int e0);
      int t, d, found;
      for (int c = 0; c < MAXC; c++) begin
         if (mode == M_STUCK)     wave[c] = '1;
         else if (mode == M_RAND) wave[c] = NU'($urandom);
         else                     wave[c] = '0;
      end
      for (int i = 0; i < NU; i++) begin
         t_clk[i] = -1;
         t_rel[i] = -1;
      end
      t_done  = -1;
      t_err   = -1;
      err_idx = 0;
      t       = e0;
      for (int i = 0; i < NU; i++) begin
         t_clk[i] = t;
         t_rel[i] = t + GAP;
         case (mode)
            M_NOM:   d = 3;
            M_TMO2:  d = (i == 2) ? TMO + 1 : int'($urandom_range(1, 6));
            M_BND:   d = (i == 1) ? TMO : int'($urandom_range(1, 6));
            M_RAND:  d = int'($urandom_range(1, TMO + 2));
            default: d = 1;
         endcase
         if (mode != M_STUCK) begin
            for (int k = 1; k <= TMO; k++) wave[t_rel[i] + k][i] = (k == d);
         end
         found = -1;
         for (int k = 1; k <= TMO; k++) begin
            if (found < 0 && wave[t_rel[i] + k][i]) found = t_rel[i] + k;
         end
         if (found < 0) begin
            t_err   = t_rel[i] + TMO;
            err_idx = i;
            break;
         end
         if (i == NU - 1) t_done = found;
         t = found;
      end
      end_n = ((t_done >= 0) ? t_done : t_err) + 3;
   endtask

   // One sequence run, started by rst release or by a software restart pulse.
   task automatic run_seq(input string name, input int mode, input bit from_sw,
                          input int sw_off, input int abort_off);
      int sw_n, ab_n;
      plan(mode, from_sw ? 2 : SS);
      sw_n = (sw_off == NONE) ? NONE : t_rel[0] + sw_off;
      ab_n = (abort_off == NONE) ? NONE : t_rel[1] + abort_off;
      if (!from_sw) begin
         rst = 1'b0;
         @(negedge clk_fr);
         @(negedge clk_fr);
         chk({name, "/reset_state"}, observed(), '0);
         rst = 1'b1;
      end
      for (int n = 1; n <= end_n; n++) begin
         bus.unit_ack_i   = wave[n];
         bus.sw_rst_req_i = (from_sw && n == 1) || (n == sw_n);
         @(posedge clk_fr);
         @(negedge clk_fr);
         chk($sformatf("%s@%0d", name, n), observed(), expect_at(n));
         if (n == ab_n) begin
            #2 rst = 1'b0;
            #1 chk({name, "/async_rst"}, observed(), '0);
            @(negedge clk_fr);
            chk({name, "/rst_hold"}, observed(), '0);
            break;
         end
      end
      bus.sw_rst_req_i = 1'b0;
   endtask

   initial begin
      bus.unit_ack_i   = '0;
      bus.sw_rst_req_i = 1'b0;
      #1 chk("por", observed(), '0);
      run_seq("nom_sw_in_wait", M_NOM,   1'b0, 1,    NONE);
      run_seq("nom_sw_rerun",   M_NOM,   1'b1, NONE, NONE);
      run_seq("timeout_u2",     M_TMO2,  1'b0, NONE, NONE);
      run_seq("sw_from_err",    M_BND,   1'b1, NONE, NONE);
      run_seq("boundary_u1",    M_BND,   1'b0, NONE, NONE);
      run_seq("stuck_ack",      M_STUCK, 1'b0, -3,   NONE);
      run_seq("abort_u1",       M_NOM,   1'b0, NONE, 2);
      run_seq("restart",        M_NOM,   1'b0, NONE, NONE);
      for (int r = 0; r < 6; r++) begin
         run_seq($sformatf("rand%0d", r), M_RAND, r[0], NONE, NONE);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
